// File: rtl/dpcm_pkg.sv
// Shared types for the DPCM residual path: default widths, RLE state encoding
// and the (value, run length, last) pair handed to the downstream packer.
package dpcm_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } rle_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  count;
        logic              last;
    } rle_pair_t;

endpackage

// File: rtl/dpcm_rle_encoder_if.sv
// Residual-in / run-pair-out stream bundle for the RLE stage.
// The master side is whoever feeds residuals and consumes pairs.
interface dpcm_rle_encoder_if #(
    parameter int DATA_W = dpcm_pkg::DATA_W,
    parameter int CNT_W  = dpcm_pkg::CNT_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last
    );

endinterface

// File: rtl/dpcm_rle_encoder.sv
// Run-length encoder for DPCM residuals: folds runs of equal words into
// (value, count) pairs, flushing on value change, count saturation or frame end.
module dpcm_rle_encoder
    import dpcm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    dpcm_rle_encoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_RUN = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    function automatic logic run_full(input logic [CNT_W-1:0] cnt);
        return (cnt == MAX_RUN);
    endfunction

    rle_state_t        state, state_nxt;

    logic [DATA_W-1:0] run_val_p0, run_val_nxt;
    logic [CNT_W-1:0]  run_cnt_p0, run_cnt_nxt;
    logic              last_pend_p0, last_pend_nxt;

    logic [DATA_W-1:0] pair_data_p1, pair_data_nxt;
    logic [CNT_W-1:0]  pair_cnt_p1, pair_cnt_nxt;
    logic              pair_last_p1, pair_last_nxt;

    logic              accept;
    logic              xfer;
    logic              same_run;

    // Handshake qualifiers; in_ready depends on state alone, so out_ready never reaches it.
    assign accept   = bus.in_valid && (state != EMIT);
    assign xfer     = (state == EMIT) && bus.out_ready;
    assign same_run = (bus.in_data == run_val_p0) && !run_full(run_cnt_p0);

    always_comb begin
        state_nxt     = state;
        run_val_nxt   = run_val_p0;
        run_cnt_nxt   = run_cnt_p0;
        last_pend_nxt = last_pend_p0;
        pair_data_nxt = pair_data_p1;
        pair_cnt_nxt  = pair_cnt_p1;
        pair_last_nxt = pair_last_p1;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    run_val_nxt = bus.in_data;
                    run_cnt_nxt = ONE;
                    if (bus.in_last) begin
                        pair_data_nxt = bus.in_data;
                        pair_cnt_nxt  = ONE;
                        pair_last_nxt = 1'b1;
                        state_nxt     = EMIT;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (accept) begin
                    if (same_run) begin
                        run_cnt_nxt = run_cnt_p0 + ONE;
                        if (bus.in_last) begin
                            pair_data_nxt = run_val_p0;
                            pair_cnt_nxt  = run_cnt_p0 + ONE;
                            pair_last_nxt = 1'b1;
                            state_nxt     = EMIT;
                        end
                    end else begin
                        // Close the current run; a last-flagged newcomer is emitted after it.
                        pair_data_nxt = run_val_p0;
                        pair_cnt_nxt  = run_cnt_p0;
                        pair_last_nxt = 1'b0;
                        run_val_nxt   = bus.in_data;
                        run_cnt_nxt   = ONE;
                        last_pend_nxt = bus.in_last;
                        state_nxt     = EMIT;
                    end
                end
            end

            EMIT: begin
                if (xfer) begin
                    if (pair_last_p1) begin
                        state_nxt = IDLE;
                    end else if (last_pend_p0) begin
                        pair_data_nxt = run_val_p0;
                        pair_cnt_nxt  = run_cnt_p0;
                        pair_last_nxt = 1'b1;
                        last_pend_nxt = 1'b0;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage boundary: run accumulator (p0) and output holding register (p1).
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            run_val_p0   <= '0;
            run_cnt_p0   <= '0;
            last_pend_p0 <= 1'b0;
            pair_data_p1 <= '0;
            pair_cnt_p1  <= '0;
            pair_last_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            run_val_p0   <= run_val_nxt;
            run_cnt_p0   <= run_cnt_nxt;
            last_pend_p0 <= last_pend_nxt;
            pair_data_p1 <= pair_data_nxt;
            pair_cnt_p1  <= pair_cnt_nxt;
            pair_last_p1 <= pair_last_nxt;
        end
    end

    assign bus.in_ready  = (state != EMIT);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = pair_data_p1;
    assign bus.out_count = pair_cnt_p1;
    assign bus.out_last  = pair_last_p1;

endmodule
